load_store_unit: RTL and testbench

//  Byte-serial memory master between the datapath and the byte-wide data memory.

---
 rtl/load_store_unit_if.sv | 30 +++
 rtl/load_store_unit.sv | 146 ++++++++++++++
 tb/tb_load_store_unit.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response handshake plus the byte-wide memory bus of the load/store unit.
// The master side is the datapath together with the data memory; the slave is the unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [63:0] resp_rdata;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [7:0]  mem_rdata;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  mem_addr, mem_wdata, mem_write, mem_read
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output mem_addr, mem_wdata, mem_write, mem_read
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte-serial RV64 load/store master: splits a 1/2/4/8-byte access into little-endian
// byte cycles on the data memory and returns an extended load result with a response pulse.
//
// state  | meaning
// IDLE   | ready for a request; request fields latched on accept
// ACCESS | one memory byte per cycle, byte index k = 0..N-1
// DONE   | one-cycle response (data or error)
module load_store_unit #(
  parameter int MEM_BYTES = 64
) (
  input logic               clk,
  input logic               reset,
  load_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state;
  logic [2:0]  k;
  logic [2:0]  last_k;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic        write_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [63:0] rbuf;

  logic        resp_valid_q;
  logic        resp_err_q;
  logic [63:0] resp_rdata_q;
  logic [63:0] mem_addr_q;
  logic [7:0]  mem_wdata_q;
  logic        mem_write_q;
  logic        mem_read_q;

  logic [3:0]  req_n;
  logic [64:0] req_end;
  logic        req_err;
  logic [63:0] rbuf_merged;
  logic [2:0]  k_nxt;

  // End address is formed in 65 bits so a huge base address cannot wrap into range.
  always_comb begin
    req_n       = 4'd1 << bus.req_funct3[1:0];
    req_end     = {1'b0, bus.req_addr} + 65'(req_n);
    req_err     = (bus.req_funct3 == 3'b111)
                || (bus.req_write && bus.req_funct3[2])
                || ((bus.req_addr[3:0] & (req_n - 4'd1)) != 4'd0)
                || (req_end > 65'(MEM_BYTES));
    rbuf_merged = rbuf;
    rbuf_merged[{k, 3'b000} +: 8] = bus.mem_rdata;
    k_nxt       = k + 3'd1;
  end

  function automatic logic [63:0] extend(input logic [63:0] d, input logic [1:0] size,
                                         input logic uns);
    case (size)
      2'd0:    extend = uns ? {56'd0, d[7:0]}  : {{56{d[7]}}, d[7:0]};
      2'd1:    extend = uns ? {48'd0, d[15:0]} : {{48{d[15]}}, d[15:0]};
      2'd2:    extend = uns ? {32'd0, d[31:0]} : {{32{d[31]}}, d[31:0]};
      default: extend = d;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      k            <= '0;
      last_k       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= '0;
      rbuf         <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            write_q <= bus.req_write;
            uns_q   <= bus.req_funct3[2];
            size_q  <= bus.req_funct3[1:0];
            last_k  <= 3'(req_n - 4'd1);
            k       <= '0;
            rbuf    <= '0;
            if (req_err) begin
              state        <= DONE;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              state       <= ACCESS;
              mem_addr_q  <= bus.req_addr;
              mem_wdata_q <= bus.req_wdata[7:0];
              mem_write_q <= bus.req_write;
              mem_read_q  <= !bus.req_write;
            end
          end
        end
        ACCESS: begin
          if (!write_q) rbuf <= rbuf_merged;
          if (k == last_k) begin
            state        <= DONE;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= write_q ? 64'd0 : extend(rbuf_merged, size_q, uns_q);
          end else begin
            k           <= k_nxt;
            mem_addr_q  <= addr_q + 64'(k_nxt);
            mem_wdata_q <= wdata_q[{k_nxt, 3'b000} +: 8];
          end
        end
        DONE: begin
          state        <= IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE) && !reset;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_read   = mem_read_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed spec cases, back-to-back and mid-access reset,
// then random requests checked against a byte-array memory model.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_init = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_BYTES(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Data memory seen by the DUT; ref_mem is the bench's own expectation of its contents.
  logic [7:0] mem [64];
  logic [7:0] ref_mem [64];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'(i * 37 + 5);
    end else if (bus.mem_write && bus.mem_addr < 64'd64) begin
      mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
    end
  end

  assign bus.mem_rdata = (bus.mem_addr < 64'd64) ? mem[bus.mem_addr[5:0]] : 8'h00;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_load(input logic [63:0] addr, input logic [2:0] f3);
    int n;
    logic [63:0] v;
    n = 1 << f3[1:0];
    v = 64'd0;
    for (int i = 0; i < n; i++) v = v | (64'(ref_mem[int'(addr) + i]) << (8 * i));
    if (!f3[2] && n < 8 && ((v >> (8 * n - 1)) & 64'd1) == 64'd1)
      v = v | (~64'd0 << (8 * n));
    return v;
  endfunction

  task automatic run_req(input string tag, input bit wr, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wd,
                         output logic [63:0] got_data);
    int n;
    bit err;
    logic [63:0] exp;
    int k, resp_at;
    bit seq_ok, busy_ok;
    logic got_err;
    n   = 1 << f3[1:0];
    err = (f3 == 3'b111) || (wr && f3[2]) || (addr % n != 0) || (addr > 64 - n);
    exp = (err || wr) ? 64'd0 : model_load(addr, f3);
    got_data = '0;
    got_err  = 1'b0;
    @(negedge clk);
    chk({tag, " ready"}, 64'(bus.req_ready), 64'd1);
    chk({tag, " idle_resp"}, 64'(bus.resp_valid), 64'd0);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'($urandom);
    bus.req_funct3 = 3'($urandom);
    bus.req_addr   = {$urandom, $urandom};
    bus.req_wdata  = {$urandom, $urandom};
    k = 0; resp_at = 0; seq_ok = 1'b1; busy_ok = 1'b1;
    for (int c = 1; c <= 12 && resp_at == 0; c++) begin
      @(negedge clk);
      if (bus.req_ready) busy_ok = 1'b0;
      if (bus.mem_write && bus.mem_read) seq_ok = 1'b0;
      if (bus.mem_write || bus.mem_read) begin
        if (bus.mem_addr !== addr + 64'(k) || bus.mem_write !== wr) seq_ok = 1'b0;
        if (wr && bus.mem_wdata !== 8'(wd >> (8 * k))) seq_ok = 1'b0;
        k++;
      end else if (bus.mem_addr !== 64'd0 || bus.mem_wdata !== 8'd0) begin
        seq_ok = 1'b0;
      end
      if (bus.resp_valid) begin
        resp_at  = c;
        got_err  = bus.resp_err;
        got_data = bus.resp_rdata;
      end
    end
    chk({tag, " resp_cycle"}, 64'(resp_at), err ? 64'd1 : 64'(n + 1));
    chk({tag, " err"}, 64'(got_err), 64'(err));
    chk({tag, " rdata"}, got_data, exp);
    chk({tag, " strobes"}, 64'(k), err ? 64'd0 : 64'(n));
    chk({tag, " bus_seq"}, 64'(seq_ok), 64'd1);
    chk({tag, " busy"}, 64'(busy_ok), 64'd1);
    if (wr && !err)
      for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = 8'(wd >> (8 * i));
  endtask

  initial begin
    logic [63:0] d, d1, wd, a;
    int first_ready, resp1, resp2;
    bit saw_resp;
    logic [2:0] f3;

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr = 64'd0;
    bus.req_wdata = 64'd0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'(i * 37 + 5);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst ready", 64'(bus.req_ready), 64'd0);
    chk("rst resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst strobes", 64'({bus.mem_write, bus.mem_read}), 64'd0);
    chk("rst mem_addr", bus.mem_addr, 64'd0);
    chk("rst rdata", bus.resp_rdata, 64'd0);
    reset = 1'b0;
    mem_init = 1'b0;
    @(negedge clk);
    chk("post_rst ready", 64'(bus.req_ready), 64'd1);

    run_req("SD8", 1'b1, 3'b011, 64'd8, 64'h8877665544332211, d);
    for (int i = 0; i < 8; i++) chk("SD8 membyte", 64'(mem[8 + i]), 64'(8'h11 * (i + 1)));
    run_req("LD8", 1'b0, 3'b011, 64'd8, 64'd0, d);
    chk("LD8 value", d, 64'h8877665544332211);
    run_req("LB15", 1'b0, 3'b000, 64'd15, 64'd0, d);
    chk("LB15 value", d, 64'hFFFFFFFFFFFFFF88);
    run_req("LBU15", 1'b0, 3'b100, 64'd15, 64'd0, d);
    chk("LBU15 value", d, 64'h88);
    run_req("LH14", 1'b0, 3'b001, 64'd14, 64'd0, d);
    chk("LH14 value", d, 64'hFFFFFFFFFFFF8877);
    run_req("LWU12", 1'b0, 3'b110, 64'd12, 64'd0, d);
    chk("LWU12 value", d, 64'h88776655);
    run_req("LW6 misaligned", 1'b0, 3'b010, 64'd6, 64'd0, d);
    run_req("SB unsigned", 1'b1, 3'b100, 64'd3, 64'hAB, d);
    run_req("LD64 range", 1'b0, 3'b011, 64'd64, 64'd0, d);
    run_req("funct3 111", 1'b0, 3'b111, 64'd0, 64'd0, d);
    run_req("LD wrap", 1'b0, 3'b011, 64'hFFFFFFFFFFFFFFF8, 64'd0, d);
    run_req("SD56 last", 1'b1, 3'b011, 64'd56, {$urandom, $urandom}, d);

    // req_valid held through a busy LD; the held request is a different one (LBU 15).
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_funct3 = 3'b011;
    bus.req_addr = 64'd8;
    @(posedge clk);
    #1;
    bus.req_funct3 = 3'b100;
    bus.req_addr = 64'd15;
    first_ready = 0; resp1 = 0; d1 = '0;
    for (int c = 1; c <= 14 && first_ready == 0; c++) begin
      @(negedge clk);
      if (bus.resp_valid) begin resp1 = c; d1 = bus.resp_rdata; end
      if (bus.req_ready) first_ready = c;
    end
    chk("b2b first_resp", 64'(resp1), 64'd9);
    chk("b2b first_data", d1, model_load(64'd8, 3'b011));
    chk("b2b second_accept", 64'(first_ready), 64'd10);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    resp2 = 0; d1 = '0;
    for (int c = 1; c <= 6 && resp2 == 0; c++) begin
      @(negedge clk);
      if (bus.resp_valid) begin resp2 = c; d1 = bus.resp_rdata; end
    end
    chk("b2b second_resp", 64'(resp2), 64'd2);
    chk("b2b second_data", d1, model_load(64'd15, 3'b100));

    // Reset sampled on the edge that writes byte 1 of an SD to address 0.
    wd = {$urandom, $urandom};
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_funct3 = 3'b011;
    bus.req_addr = 64'd0;
    bus.req_wdata = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid strobes", 64'({bus.mem_write, bus.mem_read}), 64'd0);
    chk("rst_mid ready", 64'(bus.req_ready), 64'd0);
    reset = 1'b0;
    saw_resp = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.resp_valid) saw_resp = 1'b1;
    end
    chk("rst_mid no_resp", 64'(saw_resp), 64'd0);
    chk("rst_mid ready_after", 64'(bus.req_ready), 64'd1);
    ref_mem[0] = wd[7:0];
    ref_mem[1] = wd[15:8];
    run_req("LD0 after rst", 1'b0, 3'b011, 64'd0, 64'd0, d);

    for (int t = 0; t < 40; t++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 71));
      run_req("rand", 1'($urandom), f3, a, {$urandom, $urandom}, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
